iir_decim_avg: RTL and testbench
================================

IIR_DECIM_AVG -- requirements
Module: iir_decim_avg

Interface
REQ-001 Parameter DECIM_LOG2, default 2; decimation ratio N = 2^DECIM_LOG2, legal range 1..4.
REQ-002 Parameter DEPTH, default 2; output buffer entries, legal range 2..4.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 din  in  18  signed filtered sample from the upstream IIR stage (dout).
REQ-006 din_valid  in  1  one-cycle strobe; din is valid while high (upstream dout_valid).
REQ-007 clr  in  1  synchronous: clears accumulator, count, buffer and ovf.
REQ-008 dout  out  18  signed decimated sample at the buffer head.
REQ-009 dout_valid  out  1  high while the buffer is non-empty.
REQ-010 dout_ready  in  1  consumer accept; pop occurs when dout_valid && dout_ready.
REQ-011 ovf  out  1  sticky; set when a result is dropped because the buffer is full.

Function
REQ-012 The block SHALL average each group of N consecutive accepted din samples and emit one 18-bit result per group.
REQ-013 Accumulator width SHALL be 18+DECIM_LOG2 bits, signed; sign-extend din and never wrap.
REQ-014 The cnt counter (DECIM_LOG2 bits) SHALL increment on each din_valid and wrap from N-1 to 0.
REQ-015 FSM states: ACC (accumulating), PUSH (write result to buffer); reset state ACC.
REQ-016 ACC: din_valid with cnt<N-1 -> acc += din, stay ACC.
REQ-017 ACC: din_valid with cnt==N-1 -> res = (acc+din) arithmetic-shifted right by DECIM_LOG2, acc <= 0, go PUSH.
REQ-018 PUSH: write res into the buffer if not full, else drop it and set ovf; always return to ACC next cycle.
REQ-019 A din_valid arriving in PUSH SHALL be accumulated as sample 0 of the next group (acc <= sign-extended din, cnt <= 1).
REQ-020 Latency: dout_valid SHALL rise the cycle after PUSH when the buffer was empty (2 cycles after the Nth din_valid).
REQ-021 Buffer is a DEPTH-entry FIFO; head drives dout directly; dout holds stable while dout_valid && !dout_ready.
REQ-022 Same-cycle push and pop on a full buffer SHALL succeed without setting ovf.
REQ-023 Same-cycle push and pop on an empty buffer SHALL not occur (dout_valid low); the push lands, with dout_valid high next cycle.
REQ-024 Pop with buffer empty SHALL be ignored; pointers wrap modulo DEPTH.
REQ-025 dout SHALL read 0 when the buffer is empty.
REQ-026 clr SHALL take priority over din_valid and dout_ready in the same cycle; the FSM returns to ACC.

Reset
REQ-027 While rst is high: acc=0, cnt=0, FSM=ACC, buffer empty, dout=0, dout_valid=0, ovf=0.
REQ-028 rst asserted mid-group or mid-PUSH SHALL discard the partial sum and the pending result; the first group after release starts at cnt=0.

Configuration
REQ-029 Macro IIR_DECIM_ROUND_EN defined: add 2^(DECIM_LOG2-1) to the sum before the shift (round half up).
REQ-030 Macro IIR_DECIM_ROUND_EN undefined: plain arithmetic shift (floor); all other behaviour is identical.

Verification
REQ-031 N=4, din = 100, 200, 300, 401, dout_ready=1 -> dout=250 (both modes); dout_valid is high 2 cycles after the 4th strobe, for 1 cycle.
REQ-032 N=4, din = -1, -1, -1, -2 -> dout=-2 without IIR_DECIM_ROUND_EN; dout=-1 with it.
REQ-033 N=4, din = 131071 x4, then -131072 x4 -> dout = 131071, then -131072; no wrap.
REQ-034 DEPTH=2, dout_ready=0, 3 groups -> 2 results held, ovf=1 after the 3rd PUSH; dout_ready=1 then drains the first 2 results in order.
REQ-035 Buffer full, with dout_ready=1 in the same cycle as PUSH -> no ovf; occupancy stays 2.
REQ-036 rst pulse after 2 of 4 samples, then 4 samples of 8 -> dout=8; the first partial sum is not visible.

Source files
------------

// File: rtl/iir_decim_avg.sv
// Averaging decimator for the IIR output stream: sums N=2^DECIM_LOG2 samples, emits one through a small FIFO.
// Optional build macro IIR_DECIM_ROUND_EN selects round-half-up instead of floor.
module iir_decim_avg #(
  parameter int DECIM_LOG2 = 2,
  parameter int DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] din,
  input  logic        din_valid,
  input  logic        clr,
  output logic [17:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        ovf,
  output logic        o_state
);

  localparam int AW = 18 + DECIM_LOG2;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [DECIM_LOG2-1:0] LAST = '1;
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);
`ifdef IIR_DECIM_ROUND_EN
  localparam logic signed [AW-1:0] RND = AW'(1) << (DECIM_LOG2 - 1);
`else
  localparam logic signed [AW-1:0] RND = '0;
`endif

  // Handshake: a result leaves the buffer on any cycle where dout_valid && dout_ready are both high;
  // dout_valid depends only on occupancy, never on dout_ready.
  typedef enum logic {S_ACC = 1'b0, S_PUSH = 1'b1} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic signed [AW-1:0]   r_acc;
  logic [DECIM_LOG2-1:0]  r_cnt;
  logic [17:0]            r_res;
  logic [17:0]            r_mem [DEPTH];
  logic [PW-1:0]          r_wptr;
  logic [PW-1:0]          r_rptr;
  logic [CW-1:0]          r_count;
  logic                   r_ovf;

  logic signed [AW-1:0]   w_sext;
  logic signed [AW-1:0]   w_sum;
  logic [17:0]            w_res;
  logic                   w_full;
  logic                   w_wr;
  logic                   w_pop;
  logic                   w_drop;

  // Accumulator is wide enough for N full-scale samples plus the rounding bias, so it never wraps.
  assign w_sext = {{DECIM_LOG2{din[17]}}, din};
  assign w_sum  = r_acc + w_sext;
  assign w_res  = 18'((w_sum + RND) >>> DECIM_LOG2);
  assign w_full = (r_count == CW'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_ACC;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (clr) begin
      w_next = S_ACC;
    end else begin
      case (r_state)
        S_ACC:   if (din_valid && r_cnt == LAST) w_next = S_PUSH;
        S_PUSH:  w_next = S_ACC;
        default: w_next = S_ACC;
      endcase
    end
  end

  always_comb begin
    w_pop  = 1'b0;
    w_wr   = 1'b0;
    w_drop = 1'b0;
    if (!clr) begin
      w_pop = dout_valid && dout_ready;
      if (r_state == S_PUSH) begin
        w_wr   = !w_full || w_pop;
        w_drop = w_full && !w_pop;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (din_valid) begin
        if (r_state == S_PUSH) begin
          // The pending result is already latched; this sample opens the next group.
          r_acc <= w_sext;
          r_cnt <= DECIM_LOG2'(1);
        end else if (r_cnt == LAST) begin
          r_acc <= '0;
          r_cnt <= '0;
          r_res <= w_res;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_wr)  r_wptr <= (r_wptr == PTR_MAX) ? '0 : r_wptr + 1'b1;
      if (w_pop) r_rptr <= (r_rptr == PTR_MAX) ? '0 : r_rptr + 1'b1;
      if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= r_res;
  end

  assign dout_valid = (r_count != '0);
  assign dout       = dout_valid ? r_mem[r_rptr] : '0;
  assign ovf        = r_ovf;
  assign o_state    = r_state;

endmodule

// File: tb/tb_iir_decim_avg.sv
// Self-checking bench for iir_decim_avg: directed corner cases plus random groups against an arithmetic average model.
module tb_iir_decim_avg;

  localparam int DECIM_LOG2 = 2;
  localparam int N          = 4;
  localparam int DEPTH      = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] din = '0;
  logic        din_valid = 1'b0;
  logic        clr = 1'b0;
  logic [17:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        ovf;
  logic        o_state;

  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q[$];
  logic        model_ovf = 1'b0;

  iir_decim_avg #(.DECIM_LOG2(DECIM_LOG2), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .clr        (clr),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .ovf        (ovf),
    .o_state    (o_state)
  );

  // ---- clock / watchdog ----
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // ---- reference model: true average of the group, floor or round-half-up ----
  function automatic logic [17:0] exp_avg(input longint sum);
    longint s;
    longint q;
    s = sum;
`ifdef IIR_DECIM_ROUND_EN
    s = s + N / 2;
`endif
    if (s >= 0) q = s / N;
    else        q = -((-s + N - 1) / N);
    return q[17:0];
  endfunction

  // Result reaches the buffer if there is room or the consumer frees a slot in the same cycle.
  task automatic model_push(input logic [17:0] avg);
    if (exp_q.size() < DEPTH || dout_ready) exp_q.push_back(avg);
    else model_ovf = 1'b1;
  endtask

  // ---- driver tasks ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    din       = v[17:0];
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic send_group(input int a0, input int a1, input int a2, input int a3,
                            input int gap, output logic [17:0] avg);
    int s[4];
    s = '{a0, a1, a2, a3};
    for (int i = 0; i < 4; i++) begin
      send(s[i]);
      if (i < 3) repeat (gap) tick();
    end
    avg = exp_avg(longint'(a0) + longint'(a1) + longint'(a2) + longint'(a3));
  endtask

  // ---- scoreboard ----
  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic chk_head(input string tag);
    logic [17:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 18'h3ffff;
    chk(tag, dout, e);
  endtask

  task automatic wait_pop(input string tag);
    int n;
    n = 0;
    while (!dout_valid && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 18'(dout_valid), 18'(1));
    chk_head(tag);
    tick();
  endtask

  // ---- stimulus ----
  initial begin
    logic [17:0] avg;
    logic signed [17:0] t;
    int r[4];

    // reset state
    tick();
    chk("rst_dout", dout, 18'(0));
    chk("rst_valid", 18'(dout_valid), 18'(0));
    chk("rst_ovf", 18'(ovf), 18'(0));
    chk("rst_state", 18'(o_state), 18'(0));
    rst = 1'b0;
    tick();

    // latency and single-cycle valid with consumer always ready
    dout_ready = 1'b1;
    send_group(100, 200, 300, 401, 0, avg);
    model_push(avg);
    chk("lat_pre_valid", 18'(dout_valid), 18'(0));
    tick();
    chk("lat_valid", 18'(dout_valid), 18'(1));
    chk_head("lat_dout");
    tick();
    chk("lat_post_valid", 18'(dout_valid), 18'(0));

    // negative rounding and full-scale extremes
    send_group(-1, -1, -1, -2, 1, avg);
    model_push(avg);
    wait_pop("neg_round");
    send_group(131071, 131071, 131071, 131071, 0, avg);
    model_push(avg);
    wait_pop("max_pos");
    send_group(-131072, -131072, -131072, -131072, 0, avg);
    model_push(avg);
    wait_pop("max_neg");

    // overflow: three back-to-back groups into a 2-deep buffer with no consumer
    dout_ready = 1'b0;
    send_group(10, 20, 30, 40, 0, avg);
    model_push(avg);
    send_group(-5, -6, -7, -8, 0, avg);
    model_push(avg);
    send_group(1000, 1000, 1000, 1000, 0, avg);
    model_push(avg);
    chk("ovf_pre", 18'(ovf), 18'(0));
    tick();
    chk("ovf_set", 18'(ovf), 18'(model_ovf));
    chk("ovf_full_valid", 18'(dout_valid), 18'(1));
    dout_ready = 1'b1;
    chk_head("drain0");
    tick();
    chk_head("drain1");
    tick();
    chk("drain_empty_valid", 18'(dout_valid), 18'(0));
    chk("drain_empty_dout", dout, 18'(0));
    chk("ovf_sticky", 18'(ovf), 18'(1));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_ovf = 1'b0;
    chk("ovf_clr", 18'(ovf), 18'(0));

    // full buffer with push and pop in the same cycle
    dout_ready = 1'b0;
    send_group(1, 2, 3, 4, 0, avg);
    model_push(avg);
    send_group(50, 60, 70, 80, 0, avg);
    model_push(avg);
    tick();
    send_group(-400, 400, -400, 404, 0, avg);
    dout_ready = 1'b1;
    model_push(avg);
    chk_head("pp_head0");
    tick();
    chk("pp_ovf", 18'(ovf), 18'(model_ovf));
    chk("pp_valid", 18'(dout_valid), 18'(1));
    chk_head("pp_head1");
    tick();
    chk_head("pp_head2");
    tick();
    chk("pp_empty", 18'(dout_valid), 18'(0));

    // reset in the middle of a group
    send(1000);
    send(2000);
    rst = 1'b1;
    #2;
    chk("mid_rst_valid", 18'(dout_valid), 18'(0));
    chk("mid_rst_state", 18'(o_state), 18'(0));
    tick();
    rst = 1'b0;
    send_group(8, 8, 8, 8, 0, avg);
    model_push(avg);
    wait_pop("after_rst");

    // reset while the result is pending in PUSH
    send_group(7000, 7000, 7000, 7000, 0, avg);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("push_rst_valid", 18'(dout_valid), 18'(0));

    // clr beats a completing sample
    send(1);
    send(2);
    send(3);
    din = 18'd1000;
    din_valid = 1'b1;
    clr = 1'b1;
    tick();
    din_valid = 1'b0;
    clr = 1'b0;
    chk("clr_state", 18'(o_state), 18'(0));
    send_group(4, 8, 12, 16, 0, avg);
    model_push(avg);
    wait_pop("after_clr");

    // random groups with random gaps
    for (int g = 0; g < 12; g++) begin
      for (int k = 0; k < 4; k++) begin
        t = 18'($urandom);
        r[k] = int'(t);
      end
      send_group(r[0], r[1], r[2], r[3], $urandom_range(0, 2), avg);
      model_push(avg);
      wait_pop("rand");
    end

    // ---- report ----
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
